mac8u_acc: RTL and testbench

- Sequential multiply-accumulate stage placed directly downstream of mul8u_fast, our combinational 8x8 unsigned multiplier.
- Accepts a stream of operand pairs over a valid/ready handshake and instantiates mul8u_fast internally to form each 16-bit product.
- Sums N_TERMS products into one dot-product result, with saturation and an overflow flag.
- Presents each result on a valid/ready output port.

---
 rtl/mac8u_acc.sv | 98 +++++++++
 tb/tb_mac8u_acc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mac8u_acc.sv
// mac8u_acc: streaming 8x8 unsigned multiply-accumulate producing saturated N_TERMS dot products

// mul8u_fast: combinational 8x8 unsigned multiplier
module mul8u_fast (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    assign p = a * b;
endmodule

module mac8u_acc #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);
    logic [15:0]      prod;
    logic [15:0]      prod_q;
    logic             prod_v;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic [7:0]       cnt;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat;
    logic             term_ovf;
    logic             last;
    logic             stall;
    logic             fire;
    logic             accept;

    mul8u_fast u_mul (.a(a), .b(b), .p(prod));

    assign sum      = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod_q};
    assign term_ovf = sum[ACC_W];
    assign sat      = term_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign last     = cnt == 8'(N_TERMS - 1);
    // A completing fire may not overwrite a result the consumer has not taken yet
    assign stall    = last & out_valid & ~out_ready;
    assign fire     = prod_v & ~stall;
    assign in_ready = ~rst & ~clear & (~prod_v | fire);
    assign accept   = in_valid & in_ready;
    assign busy     = prod_v | (cnt != 8'd0);

    // Product register and accumulator; clear discards the partial group
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_v  <= 1'b0;
            prod_q  <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
        end else if (clear) begin
            prod_v  <= 1'b0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                prod_q <= prod;
                prod_v <= 1'b1;
            end else if (fire) begin
                prod_v <= 1'b0;
            end
            if (fire) begin
                acc     <= last ? '0 : sat;
                ovf_acc <= last ? 1'b0 : (ovf_acc | term_ovf);
                cnt     <= last ? 8'd0 : cnt + 8'd1;
            end
        end
    end

    // Result holding register; a new completion may load on the same edge the old one is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else if (fire & last & ~clear) begin
            out_valid <= 1'b1;
            out_acc   <= sat;
            out_ovf   <= ovf_acc | term_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mac8u_acc.sv
// tb_mac8u_acc: scoreboard bench driving three parameterisations of mac8u_acc
module tb_mac8u_acc;
    typedef struct {
        int          d;
        logic [23:0] acc;
        logic        ovf;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        iv[3];
    logic        irdy[3];
    logic        clr[3];
    logic        ov[3];
    logic        ordy[3];
    logic        ovf[3];
    logic        bsy[3];
    logic [7:0]  ia[3];
    logic [7:0]  ib[3];
    logic [23:0] oa[3];
    logic [16:0] oa1;
    logic        held[3];
    logic [23:0] hacc[3];
    logic        hovf[3];
    exp_t        exq[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign oa[1] = {7'b0, oa1};

    mac8u_acc #(.N_TERMS(4), .ACC_W(24)) u0 (
        .clk(clk), .rst(rst), .clear(clr[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(ia[0]), .b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_acc(oa[0]), .out_ovf(ovf[0]), .busy(bsy[0]));
    mac8u_acc #(.N_TERMS(3), .ACC_W(17)) u1 (
        .clk(clk), .rst(rst), .clear(clr[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(ia[1]), .b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_acc(oa1), .out_ovf(ovf[1]), .busy(bsy[1]));
    mac8u_acc #(.N_TERMS(1), .ACC_W(24)) u2 (
        .clk(clk), .rst(rst), .clear(clr[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(ia[2]), .b(ib[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_acc(oa[2]), .out_ovf(ovf[2]), .busy(bsy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input int d, input logic [23:0] acc, input logic o);
        exp_t x;
        x.d = d;
        x.acc = acc;
        x.ovf = o;
        exq.push_back(x);
    endtask

    // Present one pair and hold it until the DUT accepts it; returns 1ns after the accepting edge
    task automatic send(input int d, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        iv[d] = 1;
        ia[d] = x;
        ib[d] = y;
        @(negedge clk);
        while (!irdy[d] && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("accept", {31'b0, irdy[d]}, 1);
        @(posedge clk);
        #1 iv[d] = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exq.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        chk("drain", exq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation on every output handshake and checks hold stability
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst && ov[d]) begin
                if (held[d]) begin
                    chk("hold_acc", {8'b0, oa[d]}, {8'b0, hacc[d]});
                    chk("hold_ovf", {31'b0, ovf[d]}, {31'b0, hovf[d]});
                end
                if (ordy[d]) begin
                    if (exq.size() == 0) begin
                        chk("unexpected_out", exq.size(), 1);
                    end else begin
                        e = exq.pop_front();
                        chk("out_dut", d, e.d);
                        chk("out_acc", {8'b0, oa[d]}, {8'b0, e.acc});
                        chk("out_ovf", {31'b0, ovf[d]}, {31'b0, e.ovf});
                    end
                    held[d] = 0;
                end else begin
                    held[d] = 1;
                    hacc[d] = oa[d];
                    hovf[d] = ovf[d];
                end
            end else begin
                held[d] = 0;
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            iv[d] = 0; clr[d] = 0; ordy[d] = 1; ia[d] = 0; ib[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, ov[0]}, 0);
        chk("rst_in_ready", {31'b0, irdy[0]}, 0);
        chk("rst_busy", {31'b0, bsy[0]}, 0);
        chk("rst_out_acc", {8'b0, oa[0]}, 0);
        rst = 0;
        @(posedge clk);
        #1;
        // Test 1: basic group of four
        push(0, 24'd65314, 0);
        send(0, 1, 1); send(0, 7, 9); send(0, 15, 15); send(0, 255, 255);
        chk("t1_lat_pre", {31'b0, ov[0]}, 0);
        @(posedge clk);
        #1 chk("t1_lat", {31'b0, ov[0]}, 1);
        drain();
        chk("t1_busy", {31'b0, bsy[0]}, 0);
        // Test 2: back-pressure with consumer not ready
        ordy[0] = 0;
        push(0, 24'd260100, 0);
        push(0, 24'd260100, 0);
        for (int i = 0; i < 8; i++) send(0, 255, 255);
        @(negedge clk);
        chk("t2_in_ready", {31'b0, irdy[0]}, 0);
        chk("t2_acc", {8'b0, oa[0]}, 260100);
        repeat (3) @(negedge clk);
        chk("t2_in_ready_hold", {31'b0, irdy[0]}, 0);
        @(posedge clk);
        #1 ordy[0] = 1;
        @(posedge clk);
        #1 ordy[0] = 0;
        chk("t2_reload_valid", {31'b0, ov[0]}, 1);
        chk("t2_q_left", exq.size(), 1);
        repeat (3) @(posedge clk);
        #1 ordy[0] = 1;
        drain();
        chk("t2_busy", {31'b0, bsy[0]}, 0);
        // Test 3: saturation at ACC_W=17, sticky flag does not cross groups
        push(1, 24'd131071, 1);
        push(1, 24'd7, 0);
        send(1, 255, 255); send(1, 255, 255); send(1, 255, 255);
        send(1, 1, 1); send(1, 0, 255); send(1, 2, 3);
        drain();
        // Test 4: clear discards the partial group
        push(0, 24'd20064, 0);
        send(0, 23, 19); send(0, 128, 2);
        clr[0] = 1;
        @(posedge clk);
        #1 clr[0] = 0;
        chk("t4_busy_cleared", {31'b0, bsy[0]}, 0);
        send(0, 200, 100); send(0, 0, 0); send(0, 7, 9); send(0, 1, 1);
        drain();
        // Test 5: asynchronous reset mid-group
        send(0, 15, 15); send(0, 15, 15); send(0, 15, 15);
        chk("t5_busy_pre", {31'b0, bsy[0]}, 1);
        #2 rst = 1;
        #1;
        chk("t5_out_valid", {31'b0, ov[0]}, 0);
        chk("t5_out_acc", {8'b0, oa[0]}, 0);
        chk("t5_out_ovf", {31'b0, ovf[0]}, 0);
        chk("t5_in_ready", {31'b0, irdy[0]}, 0);
        chk("t5_busy", {31'b0, bsy[0]}, 0);
        @(posedge clk);
        #1 rst = 0;
        push(0, 24'd900, 0);
        for (int i = 0; i < 4; i++) send(0, 15, 15);
        drain();
        // Test 6: N_TERMS=1 with out_ready toggling
        push(2, 24'd0, 0);
        push(2, 24'd0, 0);
        push(2, 24'd63, 0);
        push(2, 24'd225, 0);
        fork
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1 ordy[2] = ~ordy[2];
                end
            end
            begin
                send(2, 0, 255); send(2, 255, 0); send(2, 7, 9); send(2, 15, 15);
            end
        join
        ordy[2] = 1;
        drain();
        chk("t6_busy", {31'b0, bsy[2]}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
